// File: rtl/mcp4725_i2c_writer_if.sv
// Request/status and pin-control bundle for the MCP4725 I2C write master.
// The master modport is the producer/pin side; the slave modport is the writer.
interface mcp4725_i2c_writer_if #(
    parameter int DATA_W = 12
);
    logic              start;
    logic [DATA_W-1:0] data;
    logic [1:0]        pd;
    logic              sda_in;
    logic              sda_oe;
    logic              scl_oe;
    logic              busy;
    logic              done;
    logic              nack;

    modport master (
        output start, data, pd, sda_in,
        input  sda_oe, scl_oe, busy, done, nack
    );

    modport slave (
        input  start, data, pd, sda_in,
        output sda_oe, scl_oe, busy, done, nack
    );
endinterface

// File: rtl/mcp4725_i2c_writer.sv
// Single-shot MCP4725 fast-mode write master: START, three bytes with ACK
// checks, STOP. Open-drain pins are driven through *_oe (1 = pull low).
module mcp4725_i2c_writer #(
    parameter int       CLK_HZ   = 50_000_000,
    parameter int       SCL_HZ   = 100_000,
    parameter bit [6:0] DEV_ADDR = 7'h60,
    parameter int       DATA_W   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    mcp4725_i2c_writer_if.slave  bus
);
    // Quarter-period divider; never below 2 so each quarter has a distinct last cycle.
    localparam int QRAW = CLK_HZ / (4 * SCL_HZ);
    localparam int QDIV = (QRAW < 2) ? 2 : QRAW;
    localparam int CW   = $clog2(QDIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [4:0]    slot_q, slot_d;
    logic [26:0]   shift_q, shift_d;
    logic          sda_oe_q, sda_oe_d;
    logic          scl_oe_q, scl_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          nack_q, nack_d;

    logic          qtick;
    logic          ack_slot;
    logic [11:0]   code12;

    // Pin levels for a given phase/quarter; returns {scl_oe, sda_oe}.
    function automatic logic [1:0] pins(input state_t st, input logic [1:0] qtr,
                                        input logic bit_val);
        logic [1:0] r;
        r = 2'b00;
        case (st)
            S_START: r = {1'b0, qtr[1]};
            S_BIT:   r = {~qtr[1], ~bit_val};
            S_STOP:  r = {(qtr == 2'd0), ~qtr[1]};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    assign qtick    = (qcnt_q == CW'(QDIV - 1));
    assign ack_slot = (slot_q == 5'd8) || (slot_q == 5'd17) || (slot_q == 5'd26);
    assign code12   = 12'(bus.data) << (12 - DATA_W);

    // Next-state logic: acceptance, quarter timing, bit shifting, ACK checks.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        slot_d    = slot_q;
        shift_d   = shift_q;
        nack_d    = nack_q;
        if (state_q == S_IDLE) begin
            if (bus.start) begin
                state_d   = S_START;
                qcnt_d    = '0;
                quarter_d = 2'd0;
                slot_d    = 5'd0;
                nack_d    = 1'b0;
                shift_d   = {DEV_ADDR, 1'b0, 1'b1, 2'b00, bus.pd, code12[11:8],
                             1'b1, code12[7:0], 1'b1};
            end
        end else begin
            qcnt_d = qtick ? '0 : qcnt_q + 1'b1;
            if (qtick) begin
                quarter_d = quarter_q + 2'd1;
            end
            case (state_q)
                S_START: begin
                    if (qtick && quarter_q == 2'd3) begin
                        state_d = S_BIT;
                    end
                end
                S_BIT: begin
                    // Slave ACK is read at the end of the SCL-high window's first half.
                    if (ack_slot && quarter_q == 2'd2 && qtick && bus.sda_in) begin
                        nack_d = 1'b1;
                    end
                    if (qtick && quarter_q == 2'd3) begin
                        if (ack_slot && (nack_q || slot_q == 5'd26)) begin
                            state_d = S_STOP;
                        end else begin
                            slot_d  = slot_q + 5'd1;
                            shift_d = {shift_q[25:0], 1'b0};
                        end
                    end
                end
                S_STOP: begin
                    if (qtick && quarter_q == 2'd3) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        {scl_oe_d, sda_oe_d} = pins(state_d, quarter_d, shift_d[26]);
        busy_d = (state_d != S_IDLE);
        done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
    end

    // State and registered outputs; reset releases both lines immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            quarter_q <= 2'd0;
            slot_q    <= 5'd0;
            shift_q   <= '0;
            sda_oe_q  <= 1'b0;
            scl_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            slot_q    <= slot_d;
            shift_q   <= shift_d;
            sda_oe_q  <= sda_oe_d;
            scl_oe_q  <= scl_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            nack_q    <= nack_d;
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign bus.scl_oe = scl_oe_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.nack   = nack_q;
endmodule
